// File: rtl/compressor_pkg.sv
// Shared types and helpers for the compressor error-sweep engine.
package compressor_pkg;

    localparam int LFSR_MIN_W = 4;
    localparam int LFSR_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_t;

    // Maximal-length Fibonacci taps; bit (t-1) set for tap t, shift toward MSB.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int width);
        logic [LFSR_MAX_W-1:0] taps;
        case (width)
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0060;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/compressor_err_sweep_lfsr_gen.sv
// Loadable Fibonacci LFSR used as the random vector source of the sweep.
module lfsr_gen
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_advance,
    input  logic [W-1:0] i_seed,
    output logic [W-1:0] o_state
);
    import compressor_pkg::*;

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] r_state;
    logic         w_feedback;

    assign w_feedback = ^(r_state & TAPS);
    assign o_state    = r_state;

    // An all-zero seed would lock the register, so it is replaced by 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= (i_seed == '0) ? W'(1) : i_seed;
        end else if (i_advance) begin
            r_state <= {r_state[W-2:0], w_feedback};
        end
    end

endmodule

// File: rtl/compressor_err_sweep.sv
// Error-characterisation engine: drives vectors to an exact/approximate
// compressor pair and accumulates error statistics after a fixed latency.
module compressor_err_sweep
    import compressor_pkg::*;
#(
    parameter  int IN_W  = 8,
    parameter  int OUT_W = 2,
    parameter  int LAT   = 1,
    localparam int CNT_W = IN_W + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic [CNT_W-1:0]       num_vec,
    input  logic [IN_W-1:0]        seed,
    input  logic [OUT_W-1:0]       exact_res,
    input  logic [OUT_W-1:0]       approx_res,
    output logic [IN_W-1:0]        vec,
    output logic                   vec_valid,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       vec_count,
    output logic [CNT_W-1:0]       err_count,
    output logic [CNT_W+OUT_W-1:0] sum_abs_err,
    output logic [CNT_W+OUT_W:0]   sum_err,
    output logic [OUT_W-1:0]       max_abs_err
);

    localparam int SUM_W  = CNT_W + OUT_W;
    localparam int SERR_W = CNT_W + OUT_W + 1;
    localparam int DRN_W  = $clog2(LAT + 1) + 1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(LAT);
    localparam logic [CNT_W-1:0] VEC_LAST = {1'b0, {IN_W{1'b1}}};

    sweep_state_t       r_state;
    logic               r_mode;
    logic [CNT_W-1:0]   r_addr;
    logic [CNT_W-1:0]   r_last;
    logic [DRN_W-1:0]   r_drain;
    logic               r_vec_valid;
    logic               r_busy;
    logic               r_done;

    logic [CNT_W-1:0]   r_vec_count;
    logic [CNT_W-1:0]   r_err_count;
    logic [SUM_W-1:0]   r_sum_abs;
    logic [SERR_W-1:0]  r_sum_err;
    logic [OUT_W-1:0]   r_max_abs;

    logic               w_accept;
    logic               w_last;
    logic               w_score;
    logic               w_lfsr_adv;
    logic [IN_W-1:0]    w_lfsr_state;
    logic signed [OUT_W:0] w_diff;
    logic [OUT_W:0]     w_neg;
    logic [OUT_W-1:0]   w_abs;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_last     = (r_addr == r_last);
    assign w_lfsr_adv = (r_state == RUN) && r_mode && !w_last;

    lfsr_gen #(
        .W (IN_W)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_accept),
        .i_advance (w_lfsr_adv),
        .i_seed    (seed),
        .o_state   (w_lfsr_state)
    );

    assign vec         = r_mode ? w_lfsr_state : r_addr[IN_W-1:0];
    assign vec_valid   = r_vec_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign vec_count   = r_vec_count;
    assign err_count   = r_err_count;
    assign sum_abs_err = r_sum_abs;
    assign sum_err     = r_sum_err;
    assign max_abs_err = r_max_abs;

    // DRAIN lasts LAT+1 cycles so the final result is scored before done rises;
    // an empty LFSR run enters DRAIN already at its terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mode      <= 1'b0;
            r_addr      <= '0;
            r_last      <= '0;
            r_drain     <= '0;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_addr <= '0;
                        r_busy <= 1'b1;
                        if (mode && (num_vec == '0)) begin
                            r_state     <= DRAIN;
                            r_drain     <= DRN_LAST;
                            r_vec_valid <= 1'b0;
                        end else begin
                            r_state     <= RUN;
                            r_vec_valid <= 1'b1;
                            r_last      <= mode ? (num_vec - CNT_W'(1)) : VEC_LAST;
                        end
                    end
                end
                RUN: begin
                    if (w_last) begin
                        r_state     <= DRAIN;
                        r_drain     <= '0;
                        r_vec_valid <= 1'b0;
                    end else begin
                        r_addr <= r_addr + CNT_W'(1);
                    end
                end
                DRAIN: begin
                    if (r_drain == DRN_LAST) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + DRN_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    generate
        if (LAT == 0) begin : g_valid_comb
            assign w_score = r_vec_valid;
        end else begin : g_valid_pipe
            logic [LAT-1:0] r_pipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe[0] <= r_vec_valid;
                    for (int i = 1; i < LAT; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end
            assign w_score = r_pipe[LAT-1];
        end
    endgenerate

    assign w_diff = $signed({1'b0, exact_res}) - $signed({1'b0, approx_res});
    assign w_neg  = -w_diff;
    assign w_abs  = w_diff[OUT_W] ? w_neg[OUT_W-1:0] : w_diff[OUT_W-1:0];

    // Clearing on an accepted start wins; metrics otherwise hold in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec_count <= '0;
            r_err_count <= '0;
            r_sum_abs   <= '0;
            r_sum_err   <= '0;
            r_max_abs   <= '0;
        end else if (w_accept) begin
            r_vec_count <= '0;
            r_err_count <= '0;
            r_sum_abs   <= '0;
            r_sum_err   <= '0;
            r_max_abs   <= '0;
        end else if (w_score) begin
            r_vec_count <= r_vec_count + CNT_W'(1);
            if (w_diff != '0) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
            r_sum_abs <= r_sum_abs + {{(SUM_W-OUT_W){1'b0}}, w_abs};
            r_sum_err <= r_sum_err + {{(SERR_W-OUT_W-1){w_diff[OUT_W]}}, w_diff};
            if (w_abs > r_max_abs) begin
                r_max_abs <= w_abs;
            end
        end
    end

endmodule

// File: tb/tb_compressor_err_sweep.sv
// Randomised self-checking bench: two sweep engines (LAT=1 and LAT=3) driving
// popcount-based bench compressors, scored against a list-based reference model.
module tb_compressor_err_sweep;
    import compressor_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        startReq;
    logic        useB;
    logic        mode;
    logic [8:0]  numVec;
    logic [7:0]  seed;
    int          approxSel;
    logic [1:0]  randTbl [256];

    logic        startA, startB;
    logic [1:0]  exactA = 2'b00, approxA = 2'b00;
    logic [1:0]  exactB = 2'b00, approxB;
    logic [1:0]  b1 = 2'b00, b2 = 2'b00;
    logic [7:0]  vecA, vecB;
    logic        validA, validB, busyA, busyB, doneA, doneB;
    logic [8:0]  vecCntA, vecCntB, errCntA, errCntB;
    logic [10:0] sumAbsA, sumAbsB;
    logic [11:0] sumErrA, sumErrB;
    logic [1:0]  maxAbsA, maxAbsB;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int doneCnt = 0;
    logic [7:0] seq[$];
    int expVecs[$];
    int expCnt, expErr, expAbs, expSum, expMax;

    assign startA  = startReq && !useB;
    assign startB  = startReq && useB;
    assign approxB = 2'b00;

    compressor_err_sweep #(.IN_W(8), .OUT_W(2), .LAT(1)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .mode(mode), .num_vec(numVec),
        .seed(seed), .exact_res(exactA), .approx_res(approxA), .vec(vecA),
        .vec_valid(validA), .busy(busyA), .done(doneA), .vec_count(vecCntA),
        .err_count(errCntA), .sum_abs_err(sumAbsA), .sum_err(sumErrA),
        .max_abs_err(maxAbsA)
    );

    compressor_err_sweep #(.IN_W(8), .OUT_W(2), .LAT(3)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .mode(mode), .num_vec(numVec),
        .seed(seed), .exact_res(exactB), .approx_res(approxB), .vec(vecB),
        .vec_valid(validB), .busy(busyB), .done(doneB), .vec_count(vecCntB),
        .err_count(errCntB), .sum_abs_err(sumAbsB), .sum_err(sumErrB),
        .max_abs_err(maxAbsB)
    );

    logic        sDone, sBusy, sValid;
    logic [7:0]  sVec;
    logic [8:0]  sVecCount, sErrCount;
    logic [10:0] sSumAbs;
    logic [11:0] sSumErr;
    logic [1:0]  sMaxAbs;
    assign sDone     = useB ? doneB   : doneA;
    assign sBusy     = useB ? busyB   : busyA;
    assign sValid    = useB ? validB  : validA;
    assign sVec      = useB ? vecB    : vecA;
    assign sVecCount = useB ? vecCntB : vecCntA;
    assign sErrCount = useB ? errCntB : errCntA;
    assign sSumAbs   = useB ? sumAbsB : sumAbsA;
    assign sSumErr   = useB ? sumErrB : sumErrA;
    assign sMaxAbs   = useB ? maxAbsB : maxAbsA;

    function automatic logic [1:0] exactFn(input logic [7:0] v);
        return 2'($countones(v));
    endfunction

    function automatic logic [1:0] approxFn(input logic [7:0] v);
        case (approxSel)
            0:       return exactFn(v);
            1:       return exactFn(v) ^ 2'b01;
            2:       return 2'b00;
            default: return randTbl[v];
        endcase
    endfunction

    // Bench compressors: one register stage for A, three for B.
    always @(posedge clk) begin
        exactA  <= exactFn(vecA);
        approxA <= approxFn(vecA);
        b1      <= exactFn(vecB);
        b2      <= b1;
        exactB  <= b2;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sValid) seq.push_back(sVec);
        if (sDone) doneCnt++;
    end

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic buildExpected(input bit lfsr, input int n, input logic [7:0] sd);
        int s, d;
        int taps;
        taps = int'(lfsr_taps(8));
        expVecs.delete();
        s = (sd == 8'd0) ? 1 : int'(sd);
        for (int i = 0; i < n; i++) begin
            if (lfsr) begin
                expVecs.push_back(s);
                s = ((s << 1) | ($countones(s & taps) & 1)) & 255;
            end else begin
                expVecs.push_back(i);
            end
        end
        expCnt = n; expErr = 0; expAbs = 0; expSum = 0; expMax = 0;
        foreach (expVecs[i]) begin
            d = int'(exactFn(8'(expVecs[i]))) - int'(approxFn(8'(expVecs[i])));
            if (d != 0) expErr++;
            expSum += d;
            if (d < 0) d = -d;
            expAbs += d;
            if (d > expMax) expMax = d;
        end
    endtask

    task automatic checkMetrics(input string tag);
        checkOutput({tag, " vec_count"}, sVecCount, expCnt);
        checkOutput({tag, " err_count"}, sErrCount, expErr);
        checkOutput({tag, " sum_abs_err"}, sSumAbs, expAbs);
        checkOutput({tag, " sum_err"}, $signed(sSumErr), expSum);
        checkOutput({tag, " max_abs_err"}, sMaxAbs, expMax);
    endtask

    task automatic waitDone(input string tag, input int k, input int expDelta,
                            output bit seen);
        int guard = 0;
        while (!sDone && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        seen = sDone;
        checkOutput({tag, " done seen"}, sDone, 1);
        if (seen) checkOutput({tag, " done edge"}, cyc - k, expDelta);
    endtask

    task automatic applyStimulus(input bit selB, input bit m, input int n,
                                 input logic [7:0] sd, input int aSel, input string tag);
        int nVec, lat, k;
        bit seen;
        useB = selB;
        approxSel = aSel;
        lat  = selB ? 3 : 1;
        nVec = m ? n : 256;
        buildExpected(m, nVec, sd);
        @(negedge clk);
        mode = m; numVec = 9'(n); seed = sd; startReq = 1'b1;
        doneCnt = 0; seq.delete(); k = cyc + 1;
        @(negedge clk);
        startReq = 1'b0;
        checkOutput({tag, " busy@k"}, sBusy, 1);
        checkOutput({tag, " valid@k"}, sValid, (nVec > 0) ? 1 : 0);
        waitDone(tag, k, (nVec == 0) ? 1 : nVec + lat + 1, seen);
        if (seen) begin
            checkMetrics(tag);
            @(negedge clk);
            checkOutput({tag, " done fell"}, sDone, 0);
            checkOutput({tag, " busy fell"}, sBusy, 0);
            checkOutput({tag, " vec_count held"}, sVecCount, expCnt);
            checkOutput({tag, " done pulses"}, doneCnt, 1);
        end
        checkOutput({tag, " vec total"}, seq.size(), nVec);
        for (int i = 0; i < nVec && i < seq.size(); i++) begin
            checkOutput({tag, $sformatf(" vec[%0d]", i)}, seq[i], expVecs[i]);
        end
    endtask

    initial begin
        int k, guard;
        bit seen;
        for (int i = 0; i < 256; i++) randTbl[i] = 2'($urandom);
        rst_n = 1'b0; startReq = 1'b0; useB = 1'b0; mode = 1'b0;
        numVec = '0; seed = '0; approxSel = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset vec", vecA, 0);
        checkOutput("reset vec_valid", validA, 0);
        checkOutput("reset busy", busyA, 0);
        checkOutput("reset done", doneA, 0);
        checkOutput("reset vec_count", vecCntA, 0);
        checkOutput("reset sum_err", sumErrA, 0);
        checkOutput("reset B busy", busyB, 0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 1'b0, 0, 8'd0, 0, "exh equal");
        applyStimulus(1'b0, 1'b0, 0, 8'd0, 1, "exh xor1");
        applyStimulus(1'b0, 1'b0, 0, 8'd0, 2, "exh zero L1");
        applyStimulus(1'b1, 1'b0, 0, 8'd0, 2, "exh zero L3");
        applyStimulus(1'b0, 1'b0, 0, 8'd0, 3, "exh random");
        applyStimulus(1'b0, 1'b1, 10, 8'd0, 3, "lfsr seed0");
        applyStimulus(1'b0, 1'b1, 0, 8'd0, 3, "lfsr empty");
        applyStimulus(1'b0, 1'b1, 1, 8'($urandom), 3, "lfsr one");
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b0, 1'b1, $urandom_range(2, 400), 8'($urandom), 3,
                          $sformatf("lfsr rnd%0d", r));
        end

        // Reset in the middle of an exhaustive run.
        useB = 1'b0; approxSel = 3;
        @(negedge clk);
        mode = 1'b0; startReq = 1'b1; doneCnt = 0;
        @(negedge clk);
        startReq = 1'b0;
        guard = 0;
        while (!(sValid && sVec == 8'd100) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("midrun reached vec 100", sVec, 100);
        rst_n = 1'b0;
        #1;
        checkOutput("midrun rst vec", vecA, 0);
        checkOutput("midrun rst vec_valid", validA, 0);
        checkOutput("midrun rst busy", busyA, 0);
        checkOutput("midrun rst done", doneA, 0);
        checkOutput("midrun rst vec_count", vecCntA, 0);
        checkOutput("midrun rst err_count", errCntA, 0);
        checkOutput("midrun rst sum_abs_err", sumAbsA, 0);
        checkOutput("midrun rst sum_err", sumErrA, 0);
        checkOutput("midrun rst max_abs_err", maxAbsA, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        checkOutput("midrun no done pulse", doneCnt, 0);
        checkOutput("midrun stays idle", busyA, 0);
        applyStimulus(1'b0, 1'b0, 0, 8'd0, 3, "post reset");

        // Start held high: one sweep per acceptance, metrics cleared on re-accept.
        useB = 1'b0; approxSel = 1;
        buildExpected(1'b0, 256, 8'd0);
        @(negedge clk);
        mode = 1'b0; numVec = '0; seed = '0; startReq = 1'b1; doneCnt = 0;
        k = cyc + 1;
        waitDone("hold#1", k, 258, seen);
        if (seen) checkMetrics("hold#1");
        @(negedge clk);
        checkOutput("hold busy fell", sBusy, 0);
        @(negedge clk);
        checkOutput("hold re-accept busy", sBusy, 1);
        checkOutput("hold cleared vec_count", sVecCount, 0);
        checkOutput("hold cleared err_count", sErrCount, 0);
        checkOutput("hold one done", doneCnt, 1);
        k = cyc;
        startReq = 1'b0;
        waitDone("hold#2", k, 258, seen);
        if (seen) checkMetrics("hold#2");
        @(negedge clk);
        checkOutput("hold two dones", doneCnt, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
